// File: rtl/inverter_loopback_tester.sv
// Stimulus/response engine for the analog double-inverter macro: drives an LFSR
// bit stream, checks the synchronized return polarity and measures edge delay.
module inverter_loopback_tester #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_PERIOD  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] num_bits,
    input  logic [7:0] bit_period,
    input  logic       resp_in,
    output logic       stim_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] err_count,
    output logic [7:0] max_delay,
    output logic       timeout
);

    localparam int unsigned CW   = 8;
    localparam int unsigned BW   = CW + 1;
    localparam logic [CW-1:0] SEED   = 8'hA5;
    localparam logic [CW-1:0] MIN_P  = CW'(MIN_PERIOD);
    localparam logic [CW-1:0] ERR_MAX = 8'hFF;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t               state;
    logic [CW-1:0]        lfsr;
    logic [CW-1:0]        period_q;
    logic [BW-1:0]        bits_left;
    logic [CW-1:0]        slot_cnt;
    logic                 measure;
    logic                 matched;
    logic [SYNC_STAGES-1:0] sync_q;

    logic          resp_s;
    logic [CW-1:0] period_c;
    logic          slot_last;
    logic          hit;

    // Fibonacci step for x^8+x^6+x^5+x^4+1; the transmitted bit is l[7].
    function automatic logic [CW-1:0] lfsr_step(input logic [CW-1:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    assign resp_s    = sync_q[SYNC_STAGES-1];
    assign period_c  = (bit_period < MIN_P) ? MIN_P : bit_period;
    assign slot_last = (slot_cnt == CW'(period_q - 8'd1));
    // First cycle of a transition slot in which the return matches the drive.
    assign hit       = measure && !matched && (resp_s == stim_out);

    // Metastability synchronizer on the asynchronous macro return.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], resp_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= SEED;
            period_q  <= MIN_P;
            bits_left <= '0;
            slot_cnt  <= '0;
            measure   <= 1'b0;
            matched   <= 1'b0;
            stim_out  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            max_delay <= '0;
            timeout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        err_count <= '0;
                        max_delay <= '0;
                        timeout   <= 1'b0;
                        period_q  <= period_c;
                        bits_left <= (num_bits == 8'd0) ? BW'(256) : BW'(num_bits);
                        slot_cnt  <= '0;
                        stim_out  <= SEED[7];
                        lfsr      <= lfsr_step(SEED);
                        // The reference level before the first bit is 0.
                        measure   <= SEED[7];
                        matched   <= 1'b0;
                    end
                end
                RUN: begin
                    if (hit) begin
                        matched <= 1'b1;
                        if (slot_cnt > max_delay) begin
                            max_delay <= slot_cnt;
                        end
                    end
                    if (slot_last) begin
                        if (measure && !matched && (resp_s != stim_out)) begin
                            timeout <= 1'b1;
                        end
                        if ((resp_s != stim_out) && (err_count != ERR_MAX)) begin
                            err_count <= err_count + 8'd1;
                        end
                        slot_cnt <= '0;
                        if (bits_left == BW'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            bits_left <= bits_left - BW'(1);
                            stim_out  <= lfsr[7];
                            measure   <= (lfsr[7] != stim_out);
                            matched   <= 1'b0;
                            lfsr      <= lfsr_step(lfsr);
                        end
                    end else begin
                        slot_cnt <= slot_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inverter_loopback_tester.sv
// Randomized scoreboard bench for inverter_loopback_tester with a behavioural
// loopback model (ideal, stuck-at-0, inverted, delay line).
module tb_inverter_loopback_tester;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] num_bits;
    logic [7:0] bit_period;
    logic       resp_in;
    logic       stim_out;
    logic       busy;
    logic       done;
    logic [7:0] err_count;
    logic [7:0] max_delay;
    logic       timeout;

    inverter_loopback_tester dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_bits  (num_bits),
        .bit_period(bit_period),
        .resp_in   (resp_in),
        .stim_out  (stim_out),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .max_delay (max_delay),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Loopback modes: 0 ideal, 1 stuck at 0, 2 inverted, 3 delay line of dly cycles.
    int   mode = 0;
    int   dly  = 1;
    logic dl[0:7];
    int   cyc  = 0;
    int   checks = 0;
    int   errors = 0;
    bit   hold = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        dl[0] <= stim_out;
        for (int j = 1; j < 8; j++) dl[j] <= dl[j-1];
    end

    always_comb begin
        case (mode)
            0:       resp_in = stim_out;
            1:       resp_in = 1'b0;
            2:       resp_in = ~stim_out;
            default: resp_in = dl[dly-1];
        endcase
    end

    typedef struct {
        int done_cyc;
        int err;
        int maxd;
        int to;
        int last;
    } exp_t;

    exp_t q[$];

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Expected results from the waveform the loop would see, cycle t=0 being
    // the first cycle of bit 0; the synchronizer adds two cycles of lag.
    function automatic exp_t model(bit prev, int md, int d, int n, int p, int e);
        exp_t        r;
        bit          bits[256];
        logic [7:0]  l;
        bit          w[$];
        int          err, maxd, dd, t;
        bit          to, cur, pv, found, src, sv;
        l = 8'hA5;
        for (int i = 0; i < 256; i++) begin
            bits[i] = l[7];
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        for (int k = -16; k < n * p; k++) w.push_back((k < 0) ? prev : bits[k / p]);
        dd = (md == 3) ? d : 0;
        err = 0; maxd = 0; to = 1'b0;
        for (int i = 0; i < n; i++) begin
            cur   = bits[i];
            pv    = (i == 0) ? 1'b0 : bits[i-1];
            found = 1'b0;
            for (int c = 0; c < p; c++) begin
                t   = i * p + c;
                src = w[t - 2 - dd + 16];
                sv  = (md == 1) ? 1'b0 : (md == 2) ? ~src : src;
                if (cur != pv && !found && sv == cur) begin
                    found = 1'b1;
                    if (c > maxd) maxd = c;
                end
                if (c == p - 1 && sv != cur) err++;
            end
            if (cur != pv && !found) to = 1'b1;
        end
        r.done_cyc = e + 1 + n * p;
        r.err      = (err > 255) ? 255 : err;
        r.maxd     = maxd;
        r.to       = int'(to);
        r.last     = int'(bits[n-1]);
        return r;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t x;
        if (!rst && done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                x = q.pop_front();
                chk("done_cycle", cyc, x.done_cyc);
                chk("err_count", int'(err_count), x.err);
                chk("max_delay", int'(max_delay), x.maxd);
                chk("timeout", int'(timeout), x.to);
                chk("busy_at_done", int'(busy), 0);
                chk("stim_hold", int'(stim_out), x.last);
            end
        end
    end

    task automatic check_reset(string tag);
        chk({tag, "_stim_out"}, int'(stim_out), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err_count"}, int'(err_count), 0);
        chk({tag, "_max_delay"}, int'(max_delay), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
    endtask

    // Called #1 after an edge; start is sampled by the following edge.
    task automatic issue(int md, int d, int n_in, int bp, bit settle);
        exp_t x;
        int   n, p;
        if (settle) begin
            mode = md;
            dly  = d;
            repeat (12) @(posedge clk);
            #1;
        end
        n = (n_in == 0) ? 256 : n_in;
        p = (bp < 4) ? 4 : bp;
        x = model(hold, mode, dly, n, p, cyc);
        q.push_back(x);
        hold       = x.last[0];
        num_bits   = 8'(n_in);
        bit_period = 8'(bp);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(int lim);
        bit seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_done actual=no_done expected=done_within_%0d (cycle %0d)", lim, cyc);
        end
    endtask

    initial begin
        int md, d, n, bp;
        rst        = 1'b1;
        start      = 1'b0;
        num_bits   = 8'd0;
        bit_period = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset("reset");

        issue(0, 0, 8, 8, 1'b1);  wait_done(100);
        issue(1, 0, 8, 8, 1'b1);  wait_done(100);
        issue(2, 0, 8, 8, 1'b1);  wait_done(100);
        issue(3, 5, 16, 8, 1'b1); wait_done(200);
        issue(3, 5, 16, 4, 1'b1); wait_done(200);

        // Abandon a run with a mid-run reset; no done may follow.
        issue(0, 0, 8, 8, 1'b1);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        hold = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset("midrun_rst");
        repeat (80) @(posedge clk);
        #1;
        issue(0, 0, 8, 8, 1'b1);  wait_done(100);

        // A start pulse while busy must not disturb the run.
        issue(0, 0, 10, 1, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        num_bits   = 8'd3;
        bit_period = 8'd9;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(200);

        issue(0, 0, 0, 4, 1'b1);  wait_done(1100);

        // Back-to-back: next start issued in the done cycle.
        issue(0, 0, 5, 6, 1'b1);  wait_done(100);
        issue(0, 0, 7, 5, 1'b0);  wait_done(100);

        for (int k = 0; k < 10; k++) begin
            md = int'($urandom_range(0, 3));
            d  = int'($urandom_range(1, 5));
            n  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
            bp = int'($urandom_range(0, 12));
            issue(md, d, n, bp, 1'b1);
            wait_done(3200);
        end

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inverter_loopback_tester.md
# inverter_loopback_tester

Digital stimulus/response engine for the analog double-inverter macro. It drives a pseudo-random bit stream toward the macro's input pad and receives the macro's output back through a synchronizer. It counts bits that do not return with the expected (non-inverted) polarity and records the worst-case round-trip delay in clock cycles. It sits in the digital wrapper beside the analog macro: `stim_out` is routed to the macro input and `resp_in` is taken from the macro output.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on `resp_in`. Must be ≥2.
- `MIN_PERIOD`, default 4: floor applied to `bit_period`.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: one-cycle pulse that starts a run; ignored while `busy`.
- `num_bits` in 8: bits per run, latched at start; 0 means 256.
- `bit_period` in 8: clk cycles per bit, latched at start; values below `MIN_PERIOD` are treated as `MIN_PERIOD`.
- `resp_in` in 1: asynchronous return from the macro output.
- `stim_out` out 1: registered drive to the macro input.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at the end of a run.
- `err_count` out 8: mismatched bits in the last run, saturating at 255.
- `max_delay` out 8: largest measured edge delay in the last run, saturating at 255.
- `timeout` out 1: sticky; set if any edge never returned within its bit period.

## Operation
- Reset: `stim_out`=0, `busy`=0, `done`=0, `err_count`=0, `max_delay`=0, `timeout`=0, synchronizer flops=0, FSM=IDLE, LFSR=0xA5.
- FSM states and transitions:
  - IDLE → RUN on `start`. This clears `err_count`, `max_delay` and `timeout`, reloads the LFSR to 0xA5, and latches `num_bits` and the clamped period P.
  - RUN → IDLE after the last cycle of bit N, with a `done` pulse.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Feedback `fb` = l[7]^l[5]^l[4]^l[3].
  - Update `l <= {l[6:0], fb}` once per bit.
  - The transmitted bit is l[7]. The first eight bits of every run are 1,0,1,0,0,1,0,1.
- Bit slot: `stim_out` is loaded with the bit at slot cycle 0 and held for P cycles. The slot counter runs 0..P-1.
- Delay measurement (only for slots where the new bit differs from the previous `stim_out`; previous value at run start is 0):
  - The delay counter is 0 at slot cycle 0.
  - In the first slot cycle where synchronized `resp` == `stim_out`, the counter value is compared with `max_delay`, and `max_delay` is updated if larger.
  - An ideal zero-delay loopback measures exactly `SYNC_STAGES` (2).
  - If no match occurs by slot cycle P-1, `timeout` is set.
- Bit check: at slot cycle P-1, if synchronized `resp` != `stim_out`, `err_count` increments, saturating at 255.
- After the run, `stim_out` holds its last value. Results hold until the next `start` or `rst`.

## Timing
- `start` sampled at edge k: `busy`=1 and `stim_out`=bit 0 from edge k+1.
- Bit i occupies cycles k+1+i·P through k+(i+1)·P.
- `done`=1 and `busy`=0 at edge k+1+N·P. Final `err_count`, `max_delay` and `timeout` are valid in that same cycle.
- Earliest next `start` is accepted in the `done` cycle; back-to-back runs are allowed.
- `rst` mid-run: on the next edge, the block returns to reset values, the run is abandoned, and no `done` pulse is generated.
- `start` while `busy`: no effect on any state.
- `start` and `rst` asserted together: `rst` wins.
- `num_bits`=0 runs 256 bits. The LFSR never reaches the all-zero state from seed 0xA5.
- `bit_period` 0–3 behaves identically to 4.

## Test plan
- Ideal loopback (`resp_in`=`stim_out`), P=8, N=8 → `done` exactly 65 cycles after `start`; `err_count`=0; `max_delay`=2; `timeout`=0.
- `resp_in` stuck at 0, P=8, N=8 → `err_count`=4; `timeout`=1; `max_delay`=0.
- Inverted loopback (`resp_in`=~`stim_out`), P=8, N=8 → `err_count`=8; `timeout`=1.
- Loopback with a 5-cycle delay line, P=8, N=16 → `err_count`=0; `max_delay`=7. Same loopback with P=4 → `timeout`=1 and `err_count`>0.
- `rst` pulsed at cycle 20 of a P=8, N=8 run → all outputs return to reset values the next cycle; no `done`; a subsequent `start` produces the clean results of the first scenario.
- `start` pulsed mid-run and `bit_period`=1 → the mid-run `start` is ignored; the run lasts N·4 cycles; N=0 runs 256 bits with `err_count`=0 on ideal loopback.
